// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction-memory fetch and EU issue handshake bundle
// master = sequencer side, slave = memory / control-unit side.
interface instr_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            eu_done;
  logic [3:0]      eu_flag;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_valid, imem_rdata, eu_done, eu_flag
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_valid, imem_rdata, eu_done, eu_flag
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/issue sequencer with local HALT/JMP/BRF resolution
// Optional SEQ_STEP_EN adds a step input that gates each instruction out of DECODE.
module instr_sequencer #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] START_PC   = '0,
  parameter int              EU_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_STEP_EN
  input  logic             step,
`endif
  instr_sequencer_if.master bus,
  output logic [3:0]       flags,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted,
  output logic             error
);

  localparam int CNT_W = $clog2(EU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_DECODE,
    S_ISSUE,
    S_WAIT_EU,
    S_HALT
  } state_t;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [31:0]      instr_q;
  logic [3:0]       flags_q;
  logic             imem_req_q;
  logic             instr_valid_q;
  logic             busy_q;
  logic             halted_q;
  logic             error_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       opcode_d;
  logic [PC_W-1:0]  imm_d;
  logic [PC_W-1:0]  pc_inc_d;
  logic             decode_go_d;

  assign opcode_d = instr_q[31:28];
  assign imm_d    = PC_W'(instr_q[22:15]);
  assign pc_inc_d = pc_q + PC_W'(1);

`ifdef SEQ_STEP_EN
  assign decode_go_d = step;
`else
  assign decode_go_d = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= START_PC;
      instr_q       <= '0;
      flags_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      error_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      // Both strobes are single-cycle; they are only raised on entry to FETCH / ISSUE.
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q    <= S_FETCH;
            pc_q       <= START_PC;
            error_q    <= 1'b0;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          if (bus.imem_valid) begin
            instr_q <= bus.imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (decode_go_d) begin
            case (opcode_d)
              4'hF: begin
                state_q  <= S_HALT;
                busy_q   <= 1'b0;
                halted_q <= 1'b1;
              end
              4'hE: begin
                pc_q       <= imm_d;
                state_q    <= S_FETCH;
                imem_req_q <= 1'b1;
              end
              4'hD: begin
                pc_q       <= flags_q[instr_q[1:0]] ? imm_d : pc_inc_d;
                state_q    <= S_FETCH;
                imem_req_q <= 1'b1;
              end
              default: begin
                state_q       <= S_ISSUE;
                instr_valid_q <= 1'b1;
              end
            endcase
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_EU;
        end
        S_WAIT_EU: begin
          // eu_done in the final allowed cycle still completes normally.
          if (bus.eu_done) begin
            flags_q    <= bus.eu_flag;
            pc_q       <= pc_inc_d;
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end else if (cnt_q == CNT_W'(EU_TIMEOUT - 1)) begin
            cnt_q    <= CNT_W'(EU_TIMEOUT);
            error_q  <= 1'b1;
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign flags           = flags_q;
  assign pc              = pc_q;
  assign busy            = busy_q;
  assign halted          = halted_q;
  assign error           = error_q;

endmodule
